// File: rtl/md5_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// md5_pkg
//   Shared types and constants for the MD5 message loader.
//   Rev 1.0 - initial release
// ============================================================================
package md5_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        LOAD = 3'd2,
        PAD  = 3'd3,
        LENW = 3'd4,
        GO   = 3'd5,
        WAIT = 3'd6
    } md5_state_t;

    localparam logic [7:0]       PAD_BYTE      = 8'h80;
    localparam int               WORDS_PER_BLK = 16;
    localparam int               WORDS_PER_QTR = 4;
    localparam int               WI_W          = $clog2(WORDS_PER_BLK);
    localparam logic [WI_W-1:0]  LEN_LO_IDX    = 4'd14;
    localparam logic [WI_W-1:0]  LEN_HI_IDX    = 4'd15;

    // Where the next word comes from once the current write (or block) is done.
    function automatic md5_state_t fill_dest(input logic            msg_end,
                                             input logic            need80,
                                             input logic            extra,
                                             input logic [WI_W-1:0] wi);
        if (!msg_end) return FILL;
        if (need80 || extra || (wi < LEN_LO_IDX)) return PAD;
        return LENW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md5_pad_word.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// md5_pad_word
//   Masks unused bytes of a partial last word and inserts the 0x80 pad byte.
//   Rev 1.0 - initial release
// ============================================================================
module md5_pad_word
    import md5_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_bytes,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_full_last
);

    always_comb begin
        o_word = i_data;
        if (i_last) begin
            for (int b = 0; b < 4; b++) begin
                if (b == int'(i_bytes) + 1)
                    o_word[8*b +: 8] = PAD_BYTE;
                else if (b > int'(i_bytes))
                    o_word[8*b +: 8] = 8'h00;
            end
        end
    end

    assign o_full_last = i_last && (i_bytes == 2'd3);

endmodule
`default_nettype wire

// File: rtl/md5_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// md5_load_ctrl
//   MD5 message framing: padding, length field and quarter-block sequencing.
//   Optional MD5_BLK_CNT_EN adds the blk_cnt block counter output.
//   Rev 1.0 - initial release
// ============================================================================
module md5_load_ctrl
    import md5_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [1:0]   s_bytes,
    output logic [3:0]   core_load,
    output logic [127:0] core_data,
    output logic         core_first,
    output logic         core_go,
    input  logic         core_done,
    output logic         busy,
    output logic         msg_done
`ifdef MD5_BLK_CNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    localparam logic [31:0] c_PAD_WORD = {24'h0, PAD_BYTE};

    md5_state_t        r_state, w_state_nx;
    logic [WI_W-1:0]   r_wi, w_wi_nx;
    logic [31:0]       r_buf    [WORDS_PER_QTR];
    logic [31:0]       w_buf_nx [WORDS_PER_QTR];
    logic [LEN_W-1:0]  r_bit_len, w_bit_len_nx;
    logic              r_msg_end, w_msg_end_nx;
    logic              r_need80, w_need80_nx;
    logic              r_extra, w_extra_nx;
    logic              r_len_done, w_len_done_nx;
    logic              r_first, w_first_nx;
    logic              w_busy_nx, w_msg_done;
    logic              w_acc, w_wr, w_load, w_full_last;
    logic [31:0]       w_wr_data, w_pad_word;
    logic [63:0]       w_len64;
    logic [5:0]        w_inc;

    assign w_acc   = s_valid && s_ready;
    assign w_len64 = 64'(r_bit_len);
    assign w_inc   = s_last ? {({1'b0, s_bytes} + 3'd1), 3'b000} : 6'd32;

    md5_pad_word u_pad_word (
        .i_data      (s_data),
        .i_bytes     (s_bytes),
        .i_last      (s_last),
        .o_word      (w_pad_word),
        .o_full_last (w_full_last)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_wi_nx       = r_wi;
        w_buf_nx      = r_buf;
        w_bit_len_nx  = r_bit_len;
        w_msg_end_nx  = r_msg_end;
        w_need80_nx   = r_need80;
        w_extra_nx    = r_extra;
        w_len_done_nx = r_len_done;
        w_first_nx    = r_first;
        w_busy_nx     = busy;
        w_msg_done    = 1'b0;
        w_wr          = 1'b0;
        w_wr_data     = '0;

        case (r_state)
            IDLE, FILL: begin
                if (w_acc) begin
                    w_wr         = 1'b1;
                    w_wr_data    = w_pad_word;
                    w_bit_len_nx = ((r_state == IDLE) ? '0 : r_bit_len) + LEN_W'(w_inc);
                    w_msg_end_nx = s_last;
                    w_need80_nx  = w_full_last;
                    // A pad byte at index 14/15 leaves no room for the length words.
                    w_extra_nx   = s_last && !w_full_last && (r_wi >= LEN_LO_IDX);
                    if (r_state == IDLE) begin
                        w_first_nx    = 1'b1;
                        w_busy_nx     = 1'b1;
                        w_len_done_nx = 1'b0;
                    end
                end
            end
            PAD: begin
                // A pending 0x80 word is deferred to the next block when it would hit 14/15.
                w_wr      = 1'b1;
                w_wr_data = (r_need80 && (r_wi < LEN_LO_IDX)) ? c_PAD_WORD : '0;
                if (r_wi < LEN_LO_IDX)
                    w_need80_nx = 1'b0;
            end
            LENW: begin
                w_wr      = 1'b1;
                w_wr_data = (r_wi == LEN_HI_IDX) ? w_len64[63:32] : w_len64[31:0];
                if (r_wi == LEN_HI_IDX)
                    w_len_done_nx = 1'b1;
            end
            LOAD: begin
                w_state_nx = (r_wi == '0) ? GO
                                          : fill_dest(r_msg_end, r_need80, r_extra, r_wi);
            end
            GO: begin
                w_state_nx = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    if (r_len_done) begin
                        w_state_nx = IDLE;
                        w_msg_done = 1'b1;
                        w_busy_nx  = 1'b0;
                    end else begin
                        w_first_nx = 1'b0;
                        w_extra_nx = 1'b0;
                        w_state_nx = fill_dest(r_msg_end, r_need80, 1'b0, r_wi);
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (w_wr) begin
            w_buf_nx[r_wi[1:0]] = w_wr_data;
            w_wi_nx             = r_wi + 4'd1;
            w_state_nx          = (w_wi_nx[1:0] == 2'b00) ? LOAD
                                : fill_dest(w_msg_end_nx, w_need80_nx, w_extra_nx, w_wi_nx);
        end
    end

    assign w_load = w_wr && (w_wi_nx[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wi       <= '0;
            r_buf      <= '{default: '0};
            r_bit_len  <= '0;
            r_msg_end  <= 1'b0;
            r_need80   <= 1'b0;
            r_extra    <= 1'b0;
            r_len_done <= 1'b0;
            r_first    <= 1'b0;
            s_ready    <= 1'b0;
            core_load  <= '0;
            core_data  <= '0;
            core_first <= 1'b0;
            core_go    <= 1'b0;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wi       <= w_wi_nx;
            r_buf      <= w_buf_nx;
            r_bit_len  <= w_bit_len_nx;
            r_msg_end  <= w_msg_end_nx;
            r_need80   <= w_need80_nx;
            r_extra    <= w_extra_nx;
            r_len_done <= w_len_done_nx;
            r_first    <= w_first_nx;
            s_ready    <= (w_state_nx == IDLE) || (w_state_nx == FILL);
            core_load  <= w_load ? (4'b0001 << r_wi[3:2]) : 4'b0000;
            if (w_load)
                core_data <= {w_buf_nx[0], w_buf_nx[1], w_buf_nx[2], w_buf_nx[3]};
            core_first <= w_load && w_first_nx;
            core_go    <= (w_state_nx == GO);
            busy       <= w_busy_nx;
            msg_done   <= w_msg_done;
        end
    end

`ifdef MD5_BLK_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            blk_cnt <= '0;
        else if ((r_state == IDLE) && w_acc)
            blk_cnt <= '0;
        else if ((r_state == WAIT) && core_done && (blk_cnt != 16'hFFFF))
            blk_cnt <= blk_cnt + 16'd1;
    end
`else
    // No block counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_md5_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_md5_load_ctrl
//   Scoreboard bench for md5_load_ctrl with a simple core_done responder.
//   Rev 1.0 - initial release
// ============================================================================
module tb_md5_load_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [1:0]   s_bytes;
    logic [3:0]   core_load;
    logic [127:0] core_data;
    logic         core_first;
    logic         core_go;
    logic         core_done;
    logic         busy;
    logic         msg_done;
`ifdef MD5_BLK_CNT_EN
    logic [15:0]  blk_cnt;
`endif

    always #5 clk = ~clk;

    md5_load_ctrl #(.LEN_W(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_bytes    (s_bytes),
        .core_load  (core_load),
        .core_data  (core_data),
        .core_first (core_first),
        .core_go    (core_go),
        .core_done  (core_done),
        .busy       (busy),
        .msg_done   (msg_done)
`ifdef MD5_BLK_CNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    typedef logic [132:0] exp_t;   // {load, first, data}
    exp_t        exp_q[$];
    exp_t        m_exp;
    logic [31:0] msg_q[$];
    int n_checks = 0, n_errors = 0;
    int go_cnt = 0, md_cnt = 0, go_base = 0, md_base = 0, exp_blocks = 0;
    int wait_viol = 0, wait_cycles = 0, done_delay = 2;
    bit in_wait = 1'b0, abort = 1'b0;

    task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core responder: pulses core_done a programmable number of cycles after core_go.
    initial begin
        core_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (core_go) begin
                repeat (done_delay) begin @(posedge clk); #1; end
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (core_load != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_load", 144'(core_load), 144'd0);
                end else begin
                    m_exp = exp_q.pop_front();
                    check_val("quarter", {11'd0, core_load, core_first, core_data}, {11'd0, m_exp});
                end
            end
            if (core_go)  go_cnt++;
            if (msg_done) md_cnt++;
            if (in_wait) begin
                wait_cycles++;
                if (s_ready || (core_load != 4'b0000)) wait_viol++;
                if (core_done) in_wait = 1'b0;
            end
            if (core_go) in_wait = 1'b1;
        end
    end

    // Reference framing of msg_q: masked last word, 0x80, zeros, 64-bit length.
    task automatic push_expected(input int lb);
        logic [31:0] blk[$];
        logic [31:0] w;
        logic [63:0] bl;
        logic [3:0]  ld;
        exp_t        e;
        int          n;
        blk = msg_q;
        n   = msg_q.size();
        bl  = 64'((n - 1) * 32 + (lb + 1) * 8);
        if (lb != 3) begin
            w = blk[n-1];
            for (int b = 0; b < 4; b++) begin
                if (b == lb + 1)  w[8*b +: 8] = 8'h80;
                else if (b > lb)  w[8*b +: 8] = 8'h00;
            end
            blk[n-1] = w;
        end else begin
            if ((blk.size() % 16) >= 14)
                while ((blk.size() % 16) != 0) blk.push_back(32'h0);
            blk.push_back(32'h80);
        end
        while ((blk.size() % 16) != 14) blk.push_back(32'h0);
        blk.push_back(bl[31:0]);
        blk.push_back(bl[63:32]);
        for (int k = 0; k < blk.size() / 4; k++) begin
            ld = 4'b0001 << (k % 4);
            e  = {ld, (k < 4) ? 1'b1 : 1'b0, blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]};
            exp_q.push_back(e);
        end
        exp_blocks = blk.size() / 16;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int cnt = 0;
        if (abort) return;
        s_valid = 1'b1; s_data = d; s_last = last; s_bytes = nb;
        while (!s_ready && cnt < 3000) begin @(negedge clk); cnt++; end
        if (!s_ready) begin
            check_val("accept_timeout", 144'd1, 144'd0);
            abort   = 1'b1;
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_data = $urandom; s_bytes = 2'($urandom);
    endtask

    task automatic send_msg(input int lb, input int gap);
        int n = msg_q.size();
        for (int i = 0; i < n; i++) begin
            drive_word(msg_q[i], i == n - 1, (i == n - 1) ? 2'(lb) : 2'($urandom));
`ifdef MD5_BLK_CNT_EN
            if (i == 0) check_val("blk_cnt_clear", 144'(blk_cnt), 144'd0);
`endif
            repeat ($urandom_range(0, gap)) @(negedge clk);
        end
    endtask

    task automatic wait_msg();
        int cnt = 0;
        while (!abort && md_cnt == md_base && cnt < 5000) begin @(negedge clk); cnt++; end
        repeat (3) @(negedge clk);
        check_val("msg_done_pulses", 144'(md_cnt - md_base), 144'd1);
        check_val("busy_after_done", 144'(busy), 144'd0);
        check_val("go_count", 144'(go_cnt - go_base), 144'(exp_blocks));
        check_val("queue_drained", 144'(exp_q.size()), 144'd0);
        exp_q.delete();
    endtask

    task automatic run_msg(input int nw, input int lb, input int gap);
        msg_q.delete();
        for (int i = 0; i < nw; i++) msg_q.push_back($urandom);
        push_expected(lb);
        md_base = md_cnt; go_base = go_cnt;
        send_msg(lb, gap);
        wait_msg();
    endtask

    task automatic run_abc();
        msg_q.delete();
        msg_q.push_back(32'h00636261);
        exp_q.push_back({4'b0001, 1'b1, 32'h80636261, 96'd0});
        exp_q.push_back({4'b0010, 1'b1, 128'd0});
        exp_q.push_back({4'b0100, 1'b1, 128'd0});
        exp_q.push_back({4'b1000, 1'b1, 64'd0, 32'h18, 32'd0});
        exp_blocks = 1;
        md_base = md_cnt; go_base = go_cnt;
        send_msg(2, 0);
        wait_msg();
    endtask

    initial begin
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {7'd0, s_ready, core_load, core_first, core_go, busy, msg_done, core_data}, 144'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", 144'(s_ready), 144'd1);

        run_abc();
        run_msg(14, 3, 1);      // 56 bytes: 0x80 deferred to block 2
`ifdef MD5_BLK_CNT_EN
        check_val("blk_cnt_56B", 144'(blk_cnt), 144'd2);
`endif
        run_msg(14, 2, 2);      // 55 bytes
        run_msg(13, 3, 0);
        run_msg(15, 3, 0);
        run_msg(15, 0, 1);
        run_msg(16, 3, 0);
        run_msg(16, 1, 0);
        run_msg(17, 3, 2);

        done_delay = 100; wait_viol = 0; wait_cycles = 0;
        run_msg(3, 1, 0);
        check_val("wait_quiet", 144'(wait_viol), 144'd0);
        check_val("wait_length", 144'(wait_cycles >= 100), 144'd1);
        done_delay = 2;

        msg_q.delete();
        for (int i = 0; i < 6; i++) msg_q.push_back($urandom);
        exp_q.push_back({4'b0001, 1'b1, msg_q[0], msg_q[1], msg_q[2], msg_q[3]});
        md_base = md_cnt;
        for (int i = 0; i < 6; i++) drive_word(msg_q[i], 1'b0, 2'd3);
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check_val("abort_reset_outputs",
                  {7'd0, s_ready, core_load, core_first, core_go, busy, msg_done, core_data}, 144'd0);
        check_val("abort_queue", 144'(exp_q.size()), 144'd0);
        exp_q.delete();
        reset_n = 1'b1;
        @(negedge clk);
        check_val("abort_ready", 144'(s_ready), 144'd1);
        check_val("abort_no_msg_done", 144'(md_cnt - md_base), 144'd0);
        run_abc();

        for (int k = 0; k < 6; k++) begin
            done_delay = $urandom_range(1, 8);
            run_msg($urandom_range(1, 40), $urandom_range(0, 3), 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md5_load_ctrl.md
# md5_load_ctrl

Message loader and block sequencer for the MD5 compression core. It accepts a stream of 32-bit message words and applies MD5 padding and the 64-bit length field. It splits each 512-bit block into four 128-bit quarters, drives the core's quarter-load strobes, then waits for the core to finish before starting the next block. It sits between the host/bus stream interface and the MD5 core, and owns all per-message framing.

## Interface
Parameters:
- `LEN_W`, 64: width of the bit-length counter; the upper bits are zero-extended into the 64-bit length field.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  controller accepts the word this cycle.
- `s_data`  in  32  message word; first byte in [7:0], MD5 little-endian order.
- `s_last`  in  1  final word of the message.
- `s_bytes`  in  2  valid bytes in the last word, minus 1 (0 means 1 byte, 3 means 4 bytes); ignored unless `s_last` is set.
- `core_load`  out  4  one-hot quarter strobe; bit q loads block bits [511-128q : 384-128q].
- `core_data`  out  128  quarter data; word i of the block maps to bits [127-32(i%4) : 96-32(i%4)].
- `core_first`  out  1  high with every strobe of the first block; the core re-initialises its chaining value.
- `core_go`  out  1  one-cycle pulse; the block is complete and compression starts.
- `core_done`  in  1  one-cycle pulse from the core; the block is finished and the digest/chaining value is valid.
- `busy`  out  1  a message is in progress.
- `msg_done`  out  1  one-cycle pulse on the `core_done` of the final block.

## Operation
- States: IDLE, FILL, LOAD, PAD, LENW, GO, WAIT.
- IDLE: `s_ready`=1. The first accepted word moves to FILL, sets `busy`, and sets the first-block flag.
- FILL: words are written into a 4×32 quarter buffer at word index `wi` (0–15).
  - `bit_len` increments by 32 per full word, or by 8×(`s_bytes`+1) on the last word.
  - When the buffer holds 4 words, go to LOAD.
- LOAD: drive `core_load[wi/4 - 1]` and `core_data` for one cycle.
  - Return to FILL, PAD or LENW according to the current phase.
  - After quarter 3, go to GO.
- Last-word handling:
  - Partial last word: byte 0x80 goes in lane `s_bytes`+1, higher lanes are zeroed.
  - Full last word: the next word is 0x00000080, inserted in PAD.
- PAD: insert zero words up to index 14.
  - If the pad byte lands at index ≥14, zero-fill to 16, run the block, then start a new block with zeros to 14.
- LENW: word 14 = `bit_len[31:0]`, word 15 = `bit_len[63:32]`.
- GO: pulse `core_go`, then enter WAIT.
- WAIT: `s_ready`=0. On `core_done`:
  - if more message remains, go to FILL for the next block with `core_first`=0;
  - otherwise pulse `msg_done`, clear `busy`, and go to IDLE.
- `bit_len` wraps modulo 2^LEN_W without error.
- Empty messages are not supported.

## Timing
- All outputs register-driven. Reset values: `s_ready`=0, `core_load`=0, `core_data`=0, `core_first`=0, `core_go`=0, `busy`=0, `msg_done`=0.
  - `s_ready` rises to 1 one cycle after `reset_n` is released.
- Transfer rule: a word transfers on a `clk` edge with `s_valid` & `s_ready`. `s_ready` deasserts in LOAD, PAD, LENW, GO and WAIT.
- Quarter timing: each quarter strobe follows its 4th word by one cycle. Padding words take one cycle each.
- `core_go` comes one cycle after the quarter-3 strobe.
- A `core_done` in any state other than WAIT is ignored.
- `core_done` and `reset_n` low in the same cycle: reset wins.
- `reset_n` low mid-message aborts the message: FSM to IDLE, buffer and `bit_len` cleared, no `msg_done`.

## Configuration
- `MD5_BLK_CNT_EN` defined: adds output `blk_cnt` [15:0].
  - Cleared when a message starts; increments on each `core_done` in WAIT; saturates at 0xFFFF.
  - Holds its value after `msg_done` until the next message starts; reset value 0.
- Not defined: no port and no counter logic.

## Structure
- Package `md5_pkg`: state enum, `PAD_BYTE`=8'h80, `WORDS_PER_BLK`=16, `WORDS_PER_QTR`=4, length-word indices 14 and 15.
- One sub-module, `md5_pad_word`: combinational last-word masking and 0x80 insertion from `s_data`/`s_bytes`.

## Test plan
- "abc": single word 0x00636261, `s_last`=1, `s_bytes`=2. Expect:
  - quarter 0 = {0x80636261, 0, 0, 0}, quarters 1–2 zero, quarter 3 = {0, 0, 0x18, 0};
  - `core_first`=1 on all strobes, one `core_go`, and `msg_done` on `core_done`.
- 56-byte message (14 full words): two blocks.
  - Block 2 word 0 = 0x00000080, word 14 = 0x1C0.
  - `core_first`=0 on block 2.
- 55-byte message (13 full words + 3-byte last word): one block, word 13 = 0x80xxxxxx, word 14 = 0x1B8.
- Backpressure: `core_done` delayed 100 cycles. Expect `s_ready`=0 throughout WAIT, no strobes, and resume on `core_done`.
- Reset mid-message: drop `reset_n` after 6 words. Expect all outputs at reset values; the next "abc" message produces the exact vector from the first test.
- `MD5_BLK_CNT_EN`: 56-byte message gives `blk_cnt`=2 after `msg_done`; a new message clears it to 0 on its first accepted word.
